reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one 8-bit enable-loaded storage register among several requesters. Each requester raises a request with its data. The arbiter grants one requester at a time and drives the register's write-enable and data inputs for exactly one cycle per grant. It sits directly in front of the register, and its outputs connect to the register's enable and data ports.

---
 rtl/reg_write_arbiter_pkg.sv | 14 +
 rtl/reg_write_arbiter_if.sv | 39 +++
 rtl/reg_write_arbiter_rr_pick.sv | 28 ++
 rtl/reg_write_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// reg_arb_pkg: shared types, defaults and helpers for reg_write_arbiter.
package reg_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;

  // Width of the write-source id: one code per requester plus the clear code.
  function automatic int id_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: requester/register bus for reg_write_arbiter.
// i_prio exists only when REG_WRITE_ARBITER_PRIO_EN is defined.
interface reg_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*DATA_W-1:0] i_data;
  logic                      i_clr;
`ifdef REG_WRITE_ARBITER_PRIO_EN
  logic [NUM_REQ-1:0]        i_prio;
`endif
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_wr_en;
  logic [DATA_W-1:0]         o_wr_data;
  logic [ID_W-1:0]           o_wr_id;
  logic                      o_busy;

  modport master (
`ifdef REG_WRITE_ARBITER_PRIO_EN
    output i_prio,
`endif
    output i_req, i_data, i_clr,
    input  o_gnt, o_wr_en, o_wr_data, o_wr_id, o_busy
  );

  modport slave (
`ifdef REG_WRITE_ARBITER_PRIO_EN
    input  i_prio,
`endif
    input  i_req, i_data, i_clr,
    output o_gnt, o_wr_en, o_wr_data, o_wr_id, o_busy
  );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans req_i starting at ptr_i
// and returns the first set bit as one-hot plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && req_i[PW'((32'(ptr_i) + i) % N)]) begin
        valid_o = 1'b1;
        idx_o   = PW'((32'(ptr_i) + i) % N);
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of one enable-loaded
// register. A pending clear beats every requester. Optional priority class
// enabled by REG_WRITE_ARBITER_PRIO_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  reg_write_arbiter_if.slave bus
);
  localparam int PW   = $clog2(NUM_REQ);
  localparam int ID_W = id_width(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               clr_pend_q, clr_pend_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [ID_W-1:0]    wr_id_q, wr_id_d;

  logic [NUM_REQ-1:0] win_gnt;
  logic [PW-1:0]      win_idx;
  logic               win_valid;

  logic [NUM_REQ-1:0] n_gnt;
  logic [PW-1:0]      n_idx;
  logic               n_valid;

  rr_pick #(.N(NUM_REQ)) u_pick_norm (
    .req_i   (bus.i_req),
    .ptr_i   (ptr_q),
    .gnt_o   (n_gnt),
    .idx_o   (n_idx),
    .valid_o (n_valid)
  );

`ifdef REG_WRITE_ARBITER_PRIO_EN
  logic [NUM_REQ-1:0] p_gnt;
  logic [PW-1:0]      p_idx;
  logic               p_valid;

  rr_pick #(.N(NUM_REQ)) u_pick_prio (
    .req_i   (bus.i_req & bus.i_prio),
    .ptr_i   (ptr_q),
    .gnt_o   (p_gnt),
    .idx_o   (p_idx),
    .valid_o (p_valid)
  );

  assign win_gnt   = p_valid ? p_gnt : n_gnt;
  assign win_idx   = p_valid ? p_idx : n_idx;
  assign win_valid = n_valid;
`else
  assign win_gnt   = n_gnt;
  assign win_idx   = n_idx;
  assign win_valid = n_valid;
`endif

  // Next-state: arbitrate in IDLE, single write cycle in GRANT; clear latch
  // accumulates pulses from any state until the clear write is issued.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_pend_d = clr_pend_q | bus.i_clr;
    gnt_d      = '0;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    wr_id_d    = wr_id_q;
    unique case (state_q)
      IDLE: begin
        if (clr_pend_d) begin
          state_d    = GRANT;
          clr_pend_d = 1'b0;
          wr_en_d    = 1'b1;
          wr_data_d  = '0;
          wr_id_d    = ID_W'(NUM_REQ);
        end else if (win_valid) begin
          state_d   = GRANT;
          wr_en_d   = 1'b1;
          gnt_d     = win_gnt;
          wr_data_d = bus.i_data[win_idx*DATA_W +: DATA_W];
          wr_id_d   = ID_W'(win_idx);
          ptr_d     = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any write in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      clr_pend_q <= 1'b0;
      gnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_pend_q <= clr_pend_d;
      gnt_q      <= gnt_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      wr_id_q    <= wr_id_d;
    end
  end

  assign bus.o_gnt     = gnt_q;
  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_wr_id   = wr_id_q;
  assign bus.o_busy    = (state_q == GRANT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: vector table, directed corner sequences and a
// randomized run against a spec-level reference model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  reg_write_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Downstream storage register fed by the arbiter.
  logic [DW-1:0] reg_q;
  always @(posedge clk or posedge rst)
    if (rst) reg_q <= '0;
    else if (bus.o_wr_en) reg_q <= bus.o_wr_data;

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req  = '0;
    bus.i_data = '0;
    bus.i_clr  = 1'b0;
`ifdef REG_WRITE_ARBITER_PRIO_EN
    bus.i_prio = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next write cycle; returns at its negedge.
  task automatic wait_write(output int id, output logic [N-1:0] g,
                            output logic [DW-1:0] d, output int cyc);
    bit found = 1'b0;
    id = -1; g = '0; d = '0; cyc = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.o_wr_en) begin
        found = 1'b1;
        id  = int'(bus.o_wr_id);
        g   = bus.o_gnt;
        d   = bus.o_wr_data;
        cyc = c + 1;
      end
    end
    if (!found) chk("write_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [DW-1:0] dat;
    logic          clr;
    logic [N-1:0]  e_gnt;
    int            e_id;
    logic [DW-1:0] e_dat;
  } vec_t;

  vec_t          tbl[6];
  int            id, cyc, wcount;
  logic [N-1:0]  g;
  logic [DW-1:0] d;

  // Reference model state.
  int            m_ptr;
  bit            m_pend, m_busy;
  logic          e_en;
  logic [N-1:0]  e_gnt;
  logic [DW-1:0] e_data;
  int            e_id;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_req  = '0;
    bus.i_data = '0;
    bus.i_clr  = 1'b0;
`ifdef REG_WRITE_ARBITER_PRIO_EN
    bus.i_prio = '0;
`endif

    // Reset state.
    @(negedge clk);
    chk("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
    chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_data", 32'(bus.o_wr_data), 32'd0);
    chk("rst_id", 32'(bus.o_wr_id), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;

    // Table of isolated writes.
    tbl[0] = '{4'b0100, 8'hA5, 1'b0, 4'b0100, 2, 8'hA5};
    tbl[1] = '{4'b0001, 8'h3C, 1'b0, 4'b0001, 0, 8'h3C};
    tbl[2] = '{4'b1000, 8'hFF, 1'b0, 4'b1000, 3, 8'hFF};
    tbl[3] = '{4'b0010, 8'h5A, 1'b0, 4'b0010, 1, 8'h5A};
    tbl[4] = '{4'b0000, 8'h77, 1'b1, 4'b0000, 4, 8'h00};
    tbl[5] = '{4'b0100, 8'h01, 1'b0, 4'b0100, 2, 8'h01};
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      bus.i_data = $urandom;
      for (int k = 0; k < N; k++)
        if (tbl[v].req[k]) bus.i_data[k*DW +: DW] = tbl[v].dat;
      bus.i_req = tbl[v].req;
      bus.i_clr = tbl[v].clr;
      wait_write(id, g, d, cyc);
      bus.i_req = '0;
      bus.i_clr = 1'b0;
      chk($sformatf("vec%0d_id", v), 32'(id), 32'(tbl[v].e_id));
      chk($sformatf("vec%0d_gnt", v), 32'(g), 32'(tbl[v].e_gnt));
      chk($sformatf("vec%0d_data", v), 32'(d), 32'(tbl[v].e_dat));
      chk($sformatf("vec%0d_busy", v), 32'(bus.o_busy), 32'd1);
      chk($sformatf("vec%0d_lat", v), 32'(cyc), 32'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_idle", v),
          32'({bus.o_wr_en, bus.o_gnt, bus.o_busy}), 32'd0);
      chk($sformatf("vec%0d_hold", v), 32'(bus.o_wr_data), 32'(tbl[v].e_dat));
      chk($sformatf("vec%0d_reg", v), 32'(reg_q), 32'(tbl[v].e_dat));
    end

    // Reset mid-GRANT, then fairness with requesters dropping after grant.
    do_reset();
    @(negedge clk);
    bus.i_data = 32'h44332211;
    bus.i_req  = 4'b1111;
    wait_write(id, g, d, cyc);
    chk("pre_rst_id", 32'(id), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst", 32'({bus.o_wr_en, bus.o_gnt, bus.o_wr_data, bus.o_wr_id, bus.o_busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      wait_write(id, g, d, cyc);
      if (id >= 0) bus.i_req[id] = 1'b0;
      chk($sformatf("fair_drop%0d_id", i), 32'(id), 32'(i));
      chk($sformatf("fair_drop%0d_data", i), 32'(d), 32'(8'h11 * (i + 1)));
      if (i > 0) chk($sformatf("fair_drop%0d_gap", i), 32'(cyc), 32'd2);
    end

    // All four holding requests: strict rotation with no repeats.
    do_reset();
    @(negedge clk);
    bus.i_req = 4'b1111;
    for (int i = 0; i < 2 * N; i++) begin
      wait_write(id, g, d, cyc);
      chk($sformatf("fair_hold%0d_id", i), 32'(id), 32'(i % N));
      if (i > 0) chk($sformatf("fair_hold%0d_gap", i), 32'(cyc), 32'd2);
    end
    bus.i_req = '0;

    // Clear beats requesters and leaves the pointer alone.
    do_reset();
    @(negedge clk);
    bus.i_data = 32'hDDCCBBAA;
    bus.i_req  = 4'b0011;
    bus.i_clr  = 1'b1;
    wait_write(id, g, d, cyc);
    bus.i_clr = 1'b0;
    chk("clr_id", 32'(id), 32'd4);
    chk("clr_gnt", 32'(g), 32'd0);
    chk("clr_data", 32'(d), 32'd0);
    wait_write(id, g, d, cyc);
    if (id >= 0) bus.i_req[id] = 1'b0;
    chk("clr_next_id", 32'(id), 32'd0);
    chk("clr_next_gnt", 32'(g), 32'd1);
    wait_write(id, g, d, cyc);
    bus.i_req = '0;
    chk("clr_next2_id", 32'(id), 32'd1);

    // Clear pulses during a requester-1 write and right after merge into one.
    do_reset();
    @(negedge clk);
    bus.i_data = 32'h00009900;
    bus.i_req  = 4'b0010;
    wait_write(id, g, d, cyc);
    chk("cg_req_id", 32'(id), 32'd1);
    bus.i_req = '0;
    bus.i_clr = 1'b1;
    @(posedge clk);
    #1 bus.i_clr = 1'b0;
    @(negedge clk);
    chk("cg_reg_req", 32'(reg_q), 32'h99);
    bus.i_clr = 1'b1;
    wait_write(id, g, d, cyc);
    bus.i_clr = 1'b0;
    chk("cg_clr_id", 32'(id), 32'd4);
    chk("cg_clr_lat", 32'(cyc), 32'd1);
    wcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_wr_en) wcount++;
    end
    chk("cg_single_clear", 32'(wcount), 32'd0);
    chk("cg_reg_clr", 32'(reg_q), 32'd0);

`ifdef REG_WRITE_ARBITER_PRIO_EN
    // Priority requester wins over a lower-index normal one.
    do_reset();
    @(negedge clk);
    bus.i_req  = 4'b1001;
    bus.i_prio = 4'b1000;
    wait_write(id, g, d, cyc);
    if (id >= 0) bus.i_req[id] = 1'b0;
    chk("prio_first", 32'(id), 32'd3);
    wait_write(id, g, d, cyc);
    bus.i_req  = '0;
    bus.i_prio = '0;
    chk("prio_second", 32'(id), 32'd0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_pend = 1'b0; m_busy = 1'b0;
    e_en = 1'b0; e_gnt = '0; e_data = '0; e_id = 0;
    for (int cyc_i = 0; cyc_i < 400; cyc_i++) begin
      int w;
      logic [N-1:0] cand;
      @(negedge clk);
      chk($sformatf("rand%0d", cyc_i),
          32'({bus.o_busy, bus.o_wr_en, bus.o_wr_id, bus.o_gnt, bus.o_wr_data}),
          32'({m_busy, e_en, 3'(e_id), e_gnt, e_data}));
      for (int k = 0; k < N; k++) begin
        if (bus.i_req[k] && bus.o_gnt[k]) bus.i_req[k] = 1'b0;
        else if (!bus.i_req[k] && $urandom_range(0, 2) == 0) begin
          bus.i_req[k] = 1'b1;
          bus.i_data[k*DW +: DW] = DW'($urandom);
        end
      end
      bus.i_clr = ($urandom_range(0, 7) == 0);
`ifdef REG_WRITE_ARBITER_PRIO_EN
      bus.i_prio = N'($urandom);
      cand = ((bus.i_req & bus.i_prio) != '0) ? (bus.i_req & bus.i_prio) : bus.i_req;
`else
      cand = bus.i_req;
`endif
      // Outcome of the coming edge, from the arbitration rules.
      e_en  = 1'b0;
      e_gnt = '0;
      if (m_busy) begin
        m_busy = 1'b0;
        m_pend = m_pend | bus.i_clr;
      end else if (m_pend || bus.i_clr) begin
        m_pend = 1'b0; m_busy = 1'b1; e_en = 1'b1;
        e_data = '0; e_id = N;
      end else begin
        w = -1;
        for (int s = 0; s < N; s++)
          if (w < 0 && cand[(m_ptr + s) % N]) w = (m_ptr + s) % N;
        if (w >= 0) begin
          m_busy = 1'b1; e_en = 1'b1;
          e_gnt = N'(1) << w;
          e_data = bus.i_data[w*DW +: DW];
          e_id = w;
          m_ptr = (w + 1) % N;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
